// File: rtl/scan_pkg.sv
// Shared encodings and constants for the channel scan controller.
package scan_pkg;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mask_next_sel.sv
// Circular priority search: first set mask bit strictly after cur.
// wrapped flags a result at or below cur; with cur = 3 it yields the lowest set bit.
module mask_next_sel
    import scan_pkg::*;
(
    input  logic [1:0] cur,
    input  logic [3:0] mask,
    output logic [1:0] nxt,
    output logic       wrapped
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = 2'(cur + i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrapped = found && (nxt <= cur);
    end

endmodule

// File: rtl/scan_select_seq.sv
// Steps a 2-bit decoder select through the enabled channels with a fixed
// dwell per channel and an optional blanking gap; all outputs registered.
module scan_select_seq
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DEAD     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hold,
    input  logic [3:0] ch_mask,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       wrap
);

    localparam int CW = $clog2(max2(PRESCALE, DEAD) + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(DEAD - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_d, nxt_q, nxt_d;
    logic          valid_d, wrap_d, pwrap_q, pwrap_d;
    logic [1:0]    srch_cur, srch_nxt;
    logic          srch_wrapped;

    // In IDLE, searching after channel 3 returns the lowest enabled channel.
    assign srch_cur = (state_q == S_IDLE) ? 2'b11 : sel;

    mask_next_sel u_next (
        .cur     (srch_cur),
        .mask    (ch_mask),
        .nxt     (srch_nxt),
        .wrapped (srch_wrapped)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel;
        valid_d = sel_valid;
        nxt_d   = nxt_q;
        pwrap_d = pwrap_q;
        wrap_d  = 1'b0;
        if (!en || (state_q != S_IDLE && ch_mask == '0 && !hold)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sel_d   = '0;
            valid_d = 1'b0;
        end else if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (ch_mask != '0) begin
                        state_d = S_DWELL;
                        cnt_d   = '0;
                        sel_d   = srch_nxt;
                        valid_d = 1'b1;
                    end
                end
                S_DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (DEAD == 0) begin
                            sel_d  = srch_nxt;
                            wrap_d = srch_wrapped;
                        end else begin
                            state_d = S_GAP;
                            valid_d = 1'b0;
                            nxt_d   = srch_nxt;
                            pwrap_d = srch_wrapped;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = S_DWELL;
                        cnt_d   = '0;
                        sel_d   = nxt_q;
                        valid_d = 1'b1;
                        wrap_d  = pwrap_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sel_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            wrap      <= 1'b0;
            nxt_q     <= '0;
            pwrap_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel       <= sel_d;
            sel_valid <= valid_d;
            wrap      <= wrap_d;
            nxt_q     <= nxt_d;
            pwrap_q   <= pwrap_d;
        end
    end

endmodule
